// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
//
// Scan controller for a 4-digit 7-segment display. It sits directly upstream
// of a 4:1 x 4-bit digit mux (Mux4to1b4).
//
// The block holds four committed 4-bit digits and drives them onto the mux
// data inputs. It rotates the 2-bit mux select at a divided scan rate and
// produces the active-low anode enables and decimal point for the selected
// digit.
//
// New data is staged in a shadow register. It is committed only at the frame
// boundary (s wrapping 3->0), so no frame ever mixes old and new digits.
//
// Parameters:
//   SCAN_DIV    clock cycles per digit slot (>= 2)
//   CNT_W       divider counter width, 2**CNT_W >= SCAN_DIV
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   load         capture din/dp_in into the shadow register
//   din[15:0]    digit data, [3:0]=digit0 ... [15:12]=digit3
//   dp_in[3:0]   decimal point request per digit, 1 = lit
//   blank[3:0]   live per-digit blank mask, 1 = dark
//   s[1:0]       scan select to the digit mux
//   d0..d3[3:0]  committed digits to mux inputs I0..I3
//   an[3:0]      active-low anode enables
//   dp_n         active-low decimal point of the current digit
//   pend         shadow holds data not yet committed
//   frame_start  one-cycle pulse in the first cycle of s=0
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [1:0]  s,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        pend,
    output logic        frame_start
);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       s_r;
    logic [15:0]      dig_r;          // committed digits, digit0 in [3:0]
    logic [3:0]       dp_com_r;       // committed decimal points
    logic [15:0]      shadow_dig_r;
    logic [3:0]       shadow_dp_r;
    logic             pend_r;
    logic             frame_start_r;

    logic             tick_s;
    logic             commit_s;
    logic [3:0]       an_s;
    logic             dp_n_s;

    // Slot end and frame end (last cycle of the s=3 slot)
    assign tick_s   = (cnt_r == CNT_W'(SCAN_DIV - 1));
    assign commit_s = tick_s && (s_r == 2'd3);

    // Divider, scan select, shadow capture and frame-boundary commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r         <= '0;
            s_r           <= 2'd0;
            dig_r         <= 16'h0000;
            dp_com_r      <= 4'b0000;
            shadow_dig_r  <= 16'h0000;
            shadow_dp_r   <= 4'b0000;
            pend_r        <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (tick_s) begin
                cnt_r <= '0;
                s_r   <= s_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            // Registered so the pulse lands in the first cycle of s=0
            frame_start_r <= commit_s;

            // Commit reads the pre-edge shadow; a same-cycle load lands
            // in the shadow and stays pending for the next frame.
            if (commit_s && pend_r) begin
                dig_r    <= shadow_dig_r;
                dp_com_r <= shadow_dp_r;
            end else begin
                dig_r    <= dig_r;
                dp_com_r <= dp_com_r;
            end

            if (load) begin
                shadow_dig_r <= din;
                shadow_dp_r  <= dp_in;
                pend_r       <= 1'b1;
            end else if (commit_s) begin
                pend_r       <= 1'b0;
            end else begin
                pend_r       <= pend_r;
            end
        end
    end

    // Anode and decimal-point decode from registered select and live blank
    always_comb begin
        an_s   = 4'b1111;
        dp_n_s = 1'b1;
        if (!blank[s_r]) begin
            an_s[s_r] = 1'b0;
            dp_n_s    = ~dp_com_r[s_r];
        end else begin
            an_s   = 4'b1111;
            dp_n_s = 1'b1;
        end
    end

    assign s           = s_r;
    assign d0          = dig_r[3:0];
    assign d1          = dig_r[7:4];
    assign d2          = dig_r[11:8];
    assign d3          = dig_r[15:12];
    assign pend        = pend_r;
    assign frame_start = frame_start_r;
    assign an          = an_s;
    assign dp_n        = dp_n_s;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_ctrl
//
// Self-checking bench for disp_scan_ctrl with SCAN_DIV=4.
//
// The reference model tracks time as a cycle count since reset release. It
// derives the select and frame boundaries arithmetically from that count,
// and keeps a shadow/committed pair of digit words. The model is compared
// against the DUT every cycle. Directed literal checks pin the model to
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [1:0]  s;
    logic [3:0]  d0, d1, d2, d3;
    logic [3:0]  an;
    logic        dp_n;
    logic        pend;
    logic        frame_start;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 1'b0;

    // reference model state
    int          m_t;
    logic [15:0] m_shadow;
    logic [3:0]  m_shadow_dp;
    logic        m_pend;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_fs;

    disp_scan_ctrl #(.SCAN_DIV(SD), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in),
        .blank(blank), .s(s), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .an(an), .dp_n(dp_n), .pend(pend), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic bit is_commit(int t);
        return (t % (4 * SD)) == (4 * SD - 1);
    endfunction

    function automatic int sel_of(int t);
        return (t / SD) % 4;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    endtask

    // model update: time since reset, shadow capture, frame commit
    always @(posedge clk) begin
        if (!rst_n) begin
            m_t         <= 0;
            m_shadow    <= 16'h0000;
            m_shadow_dp <= 4'b0000;
            m_pend      <= 1'b0;
            m_dig       <= 16'h0000;
            m_dp        <= 4'b0000;
            m_fs        <= 1'b0;
        end else begin
            m_t  <= m_t + 1;
            m_fs <= is_commit(m_t);
            if (is_commit(m_t) && m_pend) begin
                m_dig <= m_shadow;
                m_dp  <= m_shadow_dp;
            end
            if (load) begin
                m_shadow    <= din;
                m_shadow_dp <= dp_in;
                m_pend      <= 1'b1;
            end else if (is_commit(m_t)) begin
                m_pend <= 1'b0;
            end
        end
    end

    // every-cycle compare of DUT against the model
    always @(posedge clk) begin
        int se;
        logic [3:0] an_e;
        logic [3:0] one;
        #1;
        if (chk_en) begin
            se   = sel_of(m_t);
            one  = 4'b0001;
            an_e = blank[se] ? 4'b1111 : ~(one << se);
            check("s",           {30'd0, s},           se);
            check("digits",      {16'd0, d3, d2, d1, d0}, {16'd0, m_dig});
            check("pend",        {31'd0, pend},        {31'd0, m_pend});
            check("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
            check("an",          {28'd0, an},          {28'd0, an_e});
            check("dp_n",        {31'd0, dp_n},
                  {31'd0, (blank[se] ? 1'b1 : ~m_dp[se])});
        end
    end

    // advance at negedges until the model time reaches t (bounded)
    task automatic goto(int t);
        int n = 0;
        while (m_t != t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_t != t) begin
            chk_cnt++;
            $display("FAIL goto: model time %0d expected %0d", m_t, t);
        end
    endtask

    task automatic pulse_load(logic [15:0] v, logic [3:0] dp);
        load  = 1'b1;
        din   = v;
        dp_in = dp;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b1;
        din   = 16'hFFFF;
        dp_in = 4'hF;
        blank = 4'b0000;

        // 1. reset held 3 cycles with load active
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;
        din   = 16'h0000;
        dp_in = 4'h0;
        check("rst_s",    {30'd0, s},           32'd0);
        check("rst_d",    {16'd0, d3, d2, d1, d0}, 32'd0);
        check("rst_pend", {31'd0, pend},        32'd0);
        check("rst_an",   {28'd0, an},          32'hE);
        check("rst_dp_n", {31'd0, dp_n},        32'd1);
        check("rst_fs",   {31'd0, frame_start}, 32'd0);

        // 2. free scan
        goto(4);  check("scan_an1", {28'd0, an}, 32'hD);
        goto(8);  check("scan_an2", {28'd0, an}, 32'hB);
        goto(12); check("scan_an3", {28'd0, an}, 32'h7);
        goto(15); check("scan_fs_pre", {31'd0, frame_start}, 32'd0);
        goto(16); check("scan_fs", {31'd0, frame_start}, 32'd1);
        check("scan_wrap", {28'd0, an}, 32'hE);
        goto(17); check("scan_fs_post", {31'd0, frame_start}, 32'd0);

        // 3. load at s=1, committed at the next wrap
        goto(36);
        pulse_load(16'h8421, 4'b0000);
        check("ld_pend", {31'd0, pend}, 32'd1);
        check("ld_hold", {16'd0, d3, d2, d1, d0}, 32'd0);
        goto(47); check("ld_hold2", {28'd0, d0}, 32'd0);
        goto(48);
        check("cm_d0", {28'd0, d0}, 32'd1);
        check("cm_d1", {28'd0, d1}, 32'd2);
        check("cm_d2", {28'd0, d2}, 32'd4);
        check("cm_d3", {28'd0, d3}, 32'd8);
        check("cm_pend", {31'd0, pend}, 32'd0);

        // 4a. last load in a frame wins
        goto(50); pulse_load(16'h1111, 4'b0000);
        goto(52); pulse_load(16'h2222, 4'b0000);
        goto(64); check("last_wins", {16'd0, d3, d2, d1, d0}, 32'h2222);

        // 4b. load on the commit cycle
        goto(70); pulse_load(16'h4444, 4'b0000);
        goto(79); pulse_load(16'h3333, 4'b0000);
        check("cc_old", {16'd0, d3, d2, d1, d0}, 32'h4444);
        check("cc_pend", {31'd0, pend}, 32'd1);
        goto(96);
        check("cc_new", {16'd0, d3, d2, d1, d0}, 32'h3333);
        check("cc_pend0", {31'd0, pend}, 32'd0);

        // 5. blank and decimal point
        goto(100);
        blank = 4'b0100;
        pulse_load(16'h5678, 4'b0001);
        goto(112); check("dp_s0", {31'd0, dp_n}, 32'd0);
        check("dp_an0", {28'd0, an}, 32'hE);
        goto(116); check("dp_s1", {31'd0, dp_n}, 32'd1);
        goto(120); check("bl_an2", {28'd0, an}, 32'hF);
        check("bl_dp2", {31'd0, dp_n}, 32'd1);
        goto(124); check("dp_s3", {31'd0, dp_n}, 32'd1);
        check("dp_an3", {28'd0, an}, 32'h7);
        goto(128);
        blank = 4'b0001;
        #1;
        check("bl_an0", {28'd0, an}, 32'hF);
        check("bl_dp0", {31'd0, dp_n}, 32'd1);
        blank = 4'b0000;

        // 6. reset mid-frame discards a pending load
        goto(130); pulse_load(16'hABCD, 4'b1111);
        goto(136);
        check("mr_pend", {31'd0, pend}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_s", {30'd0, s}, 32'd0);
        check("mr_pend0", {31'd0, pend}, 32'd0);
        check("mr_d", {16'd0, d3, d2, d1, d0}, 32'd0);
        goto(3);  check("mr_slot", {30'd0, s}, 32'd0);
        goto(4);  check("mr_slot1", {30'd0, s}, 32'd1);
        goto(16); check("mr_nocommit", {16'd0, d3, d2, d1, d0}, 32'd0);
        goto(24);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Scan controller for the 4-digit 7-segment display, sitting directly upstream of Mux4to1b4.
- Holds four 4-bit digit values and drives them onto the mux data inputs I0..I3.
- Generates the rotating 2-bit select s at a divided scan rate, plus the active-low anode enables and decimal point for the selected digit.
- New display data is staged in a shadow register and committed only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (≥2). At 100 MHz this gives 1 kHz per digit. Benches use 4.
- CNT_W, 17: width of the divider counter; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- load  in  1  when high, capture din/dp_in into the shadow register this cycle
- din  in  16  digit data: [3:0]=digit0 … [15:12]=digit3
- dp_in  in  4  decimal point request per digit, 1 = lit
- blank  in  4  live per-digit blank mask, 1 = digit dark
- s  out  2  scan select to Mux4to1b4.s
- d0, d1, d2, d3  out  4 each  committed digits to Mux4to1b4.I0..I3
- an  out  4  active-low anode enables
- dp_n  out  1  active-low decimal point for the current digit
- pend  out  1  shadow holds data not yet committed
- frame_start  out  1  one-cycle pulse when s wraps 3→0

Behaviour:
- Reset, sampled on the clk edge when rst_n=0:
  - cnt=0, s=0, d0..d3=0, shadow data=0, shadow dp=0, committed dp=0, pend=0, frame_start=0.
  - Reset overrides load and any pending commit.
- Divider:
  - tick = (cnt==SCAN_DIV-1).
  - On tick, cnt←0; otherwise cnt←cnt+1.
- Scan:
  - On tick, s←s+1, wrapping modulo 4 (3→0).
  - Each s value is held for exactly SCAN_DIV cycles; one frame is 4·SCAN_DIV cycles.
- Shadow capture:
  - load=1 → shadow←{din, dp_in} and pend←1.
  - Consecutive loads overwrite the shadow; the last one wins. No backpressure, so load is always accepted.
- Commit:
  - Occurs on the cycle where tick=1 and s==3.
  - That cycle frame_start←1 (registered, so the pulse is visible in the first cycle of s=0).
  - If pend=1 at commit: d0..d3 and committed dp ← shadow contents as they were before this edge, and pend←0.
  - Load in the same cycle as a commit: the commit uses the old shadow, the shadow takes the new din, and pend stays 1 (committed on the next frame).
- New digits appear on d0..d3 in the same cycle s becomes 0. Commit latency from load is 1 to 4·SCAN_DIV cycles.
- Outputs:
  - s, d0..d3, pend and frame_start are registered.
  - an and dp_n are combinational from registered s, live blank, and committed dp.
  - an = 4'b1111 if blank[s]=1; otherwise all ones except bit s=0.
  - dp_n = ~dp_committed[s] when not blanked; 1 when blanked.
- Reset mid-frame: any pending load is discarded and the scan restarts at s=0 with a full SCAN_DIV slot.
- Arithmetic: cnt is unsigned CNT_W bits; s is a 2-bit natural wrap with no overflow flag.

Test Plan (SCAN_DIV=4):
1. Reset: hold rst_n=0 for 3 cycles with load=1, din=16'hFFFF → after release s=0, d0..d3=0, pend=0, an=4'b1110, dp_n=1, frame_start=0.
2. Free scan, blank=0:
   - s steps 0,1,2,3,0 every 4 cycles.
   - an follows 1110, 1101, 1011, 0111, 1110.
   - frame_start pulses once per 16 cycles, coincident with the first cycle of s=0.
3. Load din=16'h8421 while s=1 → pend=1 next cycle and d0..d3 remain 0 until the frame wraps. Then d0=1, d1=2, d2=4, d3=8 and pend=0, so the downstream mux o tracks 0001, 0010, 0100, 1000 as s steps.
4. Ordering:
   - Load 16'h1111 then 16'h2222 within one frame → only 2222 is committed.
   - Load 16'h3333 on the exact commit cycle → the current frame commits the previous shadow; 3333 appears one frame later.
5. Blank and dp: blank=4'b0100, dp_in=4'b0001 committed → an=1111 and dp_n=1 while s=2; dp_n=0 while s=0; dp_n=1 for s=1 and s=3.
6. Reset mid-frame: load 16'hABCD (pend=1), then pulse rst_n=0 for 1 cycle at s=2 → d0..d3 stay 0, pend=0, s=0; the next frame commits nothing.
